// File: rtl/round_controller.sv
// Match sequencer for SpyMangler: gates player entry, latches the setter's code,
// runs the breaker's guess phase under an attempt limit and timeout, and keeps score.
module round_controller #(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned WIN_SCORE      = 3,
  parameter int unsigned SCORE_W        = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               p1_done,
  input  logic [9:0]         p1_value,
  input  logic [1:0]         p2_correct,
  input  logic               p2_complete,
  output logic [2:0]         phase,
  output logic               p1_enable,
  output logic               p2_enable,
  output logic               p2_clear,
  output logic [9:0]         code_out,
  output logic [3:0]         attempts_left,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               round_done,
  output logic [1:0]         winner
);

  localparam int unsigned CODE_W    = 10;
  localparam int unsigned ATTEMPT_W = 4;
  localparam int unsigned TIMER_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [TIMER_W-1:0]   TIMER_RELOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ATTEMPT_W-1:0] ATTEMPTS_INIT = ATTEMPT_W'(MAX_ATTEMPTS);
  localparam logic [SCORE_W-1:0]   SCORE_MAX     = '1;
  localparam logic [SCORE_W-1:0]   SCORE_TARGET  = SCORE_W'(WIN_SCORE);

  localparam logic [1:0] RES_CORRECT   = 2'b01;
  localparam logic [1:0] RES_INCORRECT = 2'b10;
  localparam logic [1:0] WINNER_NONE   = 2'b00;
  localparam logic [1:0] WINNER_P1     = 2'b01;
  localparam logic [1:0] WINNER_P2     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P1_ENTRY = 3'd1,
    S_ARM      = 3'd2,
    S_GUESS    = 3'd3,
    S_WIN      = 3'd4,
    S_LOSE     = 3'd5,
    S_OVER     = 3'd6
  } state_t;

  state_t               r_state;
  logic [CODE_W-1:0]    r_code;
  logic [ATTEMPT_W-1:0] r_attempts;
  logic [TIMER_W-1:0]   r_timer;
  logic [SCORE_W-1:0]   r_p1_score;
  logic [SCORE_W-1:0]   r_p2_score;
  logic [1:0]           r_winner;
  logic                 r_round_done;
  logic                 r_p1_enable;
  logic                 r_p2_enable;
  logic                 r_p2_clear;

  state_t               w_next_state;
  logic [CODE_W-1:0]    w_code;
  logic [ATTEMPT_W-1:0] w_attempts;
  logic [TIMER_W-1:0]   w_timer;
  logic [SCORE_W-1:0]   w_p1_score;
  logic [SCORE_W-1:0]   w_p2_score;
  logic [1:0]           w_winner;
  logic [SCORE_W-1:0]   w_p1_inc;
  logic [SCORE_W-1:0]   w_p2_inc;

  // State and datapath registers; enables are registered from the next state.
  always_ff @(posedge clock) begin
    if (resetn) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_attempts   <= '0;
      r_timer      <= '0;
      r_p1_score   <= '0;
      r_p2_score   <= '0;
      r_winner     <= WINNER_NONE;
      r_round_done <= 1'b0;
      r_p1_enable  <= 1'b0;
      r_p2_enable  <= 1'b0;
      r_p2_clear   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_code       <= w_code;
      r_attempts   <= w_attempts;
      r_timer      <= w_timer;
      r_p1_score   <= w_p1_score;
      r_p2_score   <= w_p2_score;
      r_winner     <= w_winner;
      r_round_done <= (r_state == S_WIN) || (r_state == S_LOSE);
      r_p1_enable  <= (w_next_state == S_P1_ENTRY);
      r_p2_enable  <= (w_next_state == S_GUESS);
      r_p2_clear   <= (w_next_state == S_ARM);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_next_state = r_state;
    w_code       = r_code;
    w_attempts   = r_attempts;
    w_timer      = r_timer;
    w_p1_score   = r_p1_score;
    w_p2_score   = r_p2_score;
    w_winner     = r_winner;
    w_p1_inc     = (r_p1_score == SCORE_MAX) ? r_p1_score : r_p1_score + SCORE_W'(1);
    w_p2_inc     = (r_p2_score == SCORE_MAX) ? r_p2_score : r_p2_score + SCORE_W'(1);

    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_P1_ENTRY;
      end
      S_P1_ENTRY: begin
        if (p1_done && (p1_value != '0)) begin
          w_code       = p1_value;
          w_attempts   = ATTEMPTS_INIT;
          w_next_state = S_ARM;
        end
      end
      S_ARM: begin
        w_timer      = TIMER_RELOAD;
        w_next_state = S_GUESS;
      end
      S_GUESS: begin
        if (p2_complete) begin
          w_next_state = S_WIN;
        end else if (p2_correct == RES_INCORRECT) begin
          // A wrong symbol costs an attempt; the retry goes back through ARM.
          if (r_attempts <= ATTEMPT_W'(1)) begin
            w_attempts   = '0;
            w_next_state = S_LOSE;
          end else begin
            w_attempts   = r_attempts - ATTEMPT_W'(1);
            w_next_state = S_ARM;
          end
        end else if (r_timer == '0) begin
          w_next_state = S_LOSE;
        end else if (p2_correct == RES_CORRECT) begin
          w_timer = TIMER_RELOAD;
        end else begin
          w_timer = r_timer - TIMER_W'(1);
        end
      end
      S_WIN: begin
        w_p2_score = w_p2_inc;
        if (w_p2_inc >= SCORE_TARGET) begin
          w_winner     = WINNER_P2;
          w_next_state = S_OVER;
        end else begin
          w_next_state = S_P1_ENTRY;
        end
      end
      S_LOSE: begin
        w_p1_score = w_p1_inc;
        if (w_p1_inc >= SCORE_TARGET) begin
          w_winner     = WINNER_P1;
          w_next_state = S_OVER;
        end else begin
          w_next_state = S_P1_ENTRY;
        end
      end
      S_OVER: begin
        if (start) begin
          w_p1_score   = '0;
          w_p2_score   = '0;
          w_winner     = WINNER_NONE;
          w_next_state = S_P1_ENTRY;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign phase         = r_state;
  assign p1_enable     = r_p1_enable;
  assign p2_enable     = r_p2_enable;
  assign p2_clear      = r_p2_clear;
  assign code_out      = r_code;
  assign attempts_left = r_attempts;
  assign p1_score      = r_p1_score;
  assign p2_score      = r_p2_score;
  assign round_done    = r_round_done;
  assign winner        = r_winner;

endmodule
